// File: rtl/csr_ext_arbiter_pkg.sv
// Shared types for the external CSR write arbiter: CSR address and external op encoding.
package csr_ext_arbiter_pkg;

    localparam int unsigned CsrAddrW = 12;

    typedef logic [CsrAddrW-1:0] csr_addr_t;

    typedef enum logic [1:0] {
        EXT_WRITE = 2'd0,
        EXT_SET   = 2'd1,
        EXT_CLEAR = 2'd2
    } ext_csr_op_t;

endpackage

// File: rtl/csr_ext_arbiter_if.sv
// Requester, core-snoop and bank-write signals of the external CSR write arbiter.
interface csr_ext_arbiter_if #(
    parameter int unsigned NumReq   = 4,
    parameter int unsigned CsrWidth = 32
);
    import csr_ext_arbiter_pkg::*;

    logic        [NumReq-1:0]                req;
    csr_addr_t   [NumReq-1:0]                req_addr;
    ext_csr_op_t [NumReq-1:0]                req_op;
    logic        [NumReq-1:0][CsrWidth-1:0]  req_data;
    logic                                    core_csr_enable;
    csr_addr_t                               core_csr_addr;
    logic        [NumReq-1:0]                gnt;
    csr_addr_t                               ext_addr;
    ext_csr_op_t                             ext_op;
    logic        [CsrWidth-1:0]              ext_data;
    logic                                    ext_write_enable;
    logic                                    busy;

    // Peripheral/core side drives requests and snoop info.
    modport master (
        output req, req_addr, req_op, req_data, core_csr_enable, core_csr_addr,
        input  gnt, ext_addr, ext_op, ext_data, ext_write_enable, busy
    );

    modport slave (
        input  req, req_addr, req_op, req_data, core_csr_enable, core_csr_addr,
        output gnt, ext_addr, ext_op, ext_data, ext_write_enable, busy
    );
endinterface

// File: rtl/csr_ext_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_picker #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic              valid_o,
    output logic [IdxW-1:0]   idx_o
);

    int unsigned      k;
    logic [IdxW-1:0]  cand;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        k       = 0;
        cand    = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            k = 32'(ptr_i) + i;
            if (k >= NumReq) begin
                k = k - NumReq;
            end
            cand = IdxW'(k);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/csr_ext_arbiter.sv
// Round-robin arbiter feeding hardware CSR writes into the bank's external port through
// a single issue slot, holding the slot while a core CSR access targets the same address.
module csr_ext_arbiter
    import csr_ext_arbiter_pkg::*;
#(
    parameter int unsigned NumReq   = 4,
    parameter int unsigned CsrWidth = 32
) (
    input  logic            clk,
    input  logic            reset,
    csr_ext_arbiter_if.slave bus
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [IdxW-1:0]     slot_idx_q, slot_idx_d;
    csr_addr_t           slot_addr_q, slot_addr_d;
    ext_csr_op_t         slot_op_q, slot_op_d;
    logic [CsrWidth-1:0] slot_data_q, slot_data_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;

    logic                slot_valid_c;
    logic                conflict_c;
    logic                issue_c;
    logic [NumReq-1:0]   slot_mask_c;
    logic [NumReq-1:0]   eligible_c;
    logic                win_valid_c;
    logic [IdxW-1:0]     win_idx_c;

    // Conflict detection and self-mask of the requester currently in the slot.
    always_comb begin
        slot_valid_c = (state_q != StIdle);
        conflict_c   = slot_valid_c && bus.core_csr_enable &&
                       (bus.core_csr_addr == slot_addr_q);
        issue_c      = slot_valid_c && !conflict_c && !reset;
        slot_mask_c  = slot_valid_c ? (NumReq'(1) << slot_idx_q) : '0;
        eligible_c   = bus.req & ~slot_mask_c;
    end

    rr_picker #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rr_picker (
        .req_i   (eligible_c),
        .ptr_i   (rr_ptr_q),
        .valid_o (win_valid_c),
        .idx_o   (win_idx_c)
    );

    // Next state: freeze on conflict, otherwise refill from the winner or go idle.
    always_comb begin
        state_d     = state_q;
        slot_idx_d  = slot_idx_q;
        slot_addr_d = slot_addr_q;
        slot_op_d   = slot_op_q;
        slot_data_d = slot_data_q;
        rr_ptr_d    = rr_ptr_q;

        if (conflict_c) begin
            state_d = StHold;
        end else if (win_valid_c) begin
            state_d     = StIssue;
            slot_idx_d  = win_idx_c;
            slot_addr_d = bus.req_addr[win_idx_c];
            slot_op_d   = bus.req_op[win_idx_c];
            slot_data_d = bus.req_data[win_idx_c];
        end else begin
            state_d = StIdle;
        end

        if (issue_c) begin
            rr_ptr_d = (slot_idx_q == IdxW'(NumReq - 1)) ? '0 : slot_idx_q + IdxW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            slot_idx_q  <= '0;
            slot_addr_q <= '0;
            slot_op_q   <= EXT_WRITE;
            slot_data_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            slot_idx_q  <= slot_idx_d;
            slot_addr_q <= slot_addr_d;
            slot_op_q   <= slot_op_d;
            slot_data_q <= slot_data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Bank-facing outputs come straight from the slot; strobe and grant gate on conflict.
    always_comb begin
        bus.gnt              = issue_c ? slot_mask_c : '0;
        bus.ext_write_enable = issue_c;
        bus.ext_addr         = slot_addr_q;
        bus.ext_op           = slot_op_q;
        bus.ext_data         = slot_data_q;
        bus.busy             = slot_valid_c;
    end

endmodule

// File: tb/tb_csr_ext_arbiter.sv
// Self-checking bench for csr_ext_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_csr_ext_arbiter;
    import csr_ext_arbiter_pkg::*;

    localparam int unsigned N = 4;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    csr_ext_arbiter_if #(.NumReq(N), .CsrWidth(W)) bus ();

    csr_ext_arbiter #(.NumReq(N), .CsrWidth(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: one pending write, a pointer, searched with modular arithmetic.
    bit          m_valid = 1'b0;
    int unsigned m_idx   = 0;
    int unsigned m_ptr   = 0;
    csr_addr_t   m_addr  = '0;
    ext_csr_op_t m_op    = EXT_WRITE;
    logic [W-1:0] m_data = '0;
    bit          m_found;
    int unsigned m_pick;

    function automatic bit m_conflict();
        return m_valid && bus.core_csr_enable && (bus.core_csr_addr == m_addr);
    endfunction

    function automatic bit m_we();
        return m_valid && !m_conflict() && !reset;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_idx   <= 0;
            m_ptr   <= 0;
            m_addr  <= '0;
            m_op    <= EXT_WRITE;
            m_data  <= '0;
        end else if (!m_conflict()) begin
            m_found = 1'b0;
            m_pick  = 0;
            for (int unsigned off = 0; off < N; off++) begin
                if (!m_found && bus.req[(m_ptr + off) % N] &&
                    !(m_valid && ((m_ptr + off) % N) == m_idx)) begin
                    m_found = 1'b1;
                    m_pick  = (m_ptr + off) % N;
                end
            end
            if (m_valid) m_ptr <= (m_idx + 1) % N;
            m_valid <= m_found;
            if (m_found) begin
                m_idx  <= m_pick;
                m_addr <= bus.req_addr[m_pick];
                m_op   <= bus.req_op[m_pick];
                m_data <= bus.req_data[m_pick];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int unsigned i, input logic [11:0] addr,
                           input ext_csr_op_t op, input logic [W-1:0] data);
        bus.req[i]      = 1'b1;
        bus.req_addr[i] = addr;
        bus.req_op[i]   = op;
        bus.req_data[i] = data;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = '0;
        bus.core_csr_enable = 1'b0;
        bus.core_csr_addr = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0000 || bus.ext_write_enable !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: gnt=%b we=%b busy=%b required 0000/0/0",
                     bus.gnt, bus.ext_write_enable, bus.busy);
        end
        checks++;
        if (bus.ext_addr !== 12'h000 || bus.ext_op !== EXT_WRITE || bus.ext_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: addr=%h op=%0d data=%h required 0/0/0",
                     bus.ext_addr, bus.ext_op, bus.ext_data);
        end
        tick();
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 12'h300, EXT_SET, 32'h8);
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0000) begin
            errors++;
            $display("FAIL single_lat0: gnt=%b required 0000", bus.gnt);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0001 || bus.ext_write_enable !== 1'b1 || bus.ext_addr !== 12'h300 ||
            bus.ext_op !== EXT_SET || bus.ext_data !== 32'h8) begin
            errors++;
            $display("FAIL single_issue: gnt=%b we=%b addr=%h op=%0d data=%h required 0001/1/300/1/8",
                     bus.gnt, bus.ext_write_enable, bus.ext_addr, bus.ext_op, bus.ext_data);
        end
        tick();
        bus.req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.ext_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b we=%b required 0/0", bus.busy, bus.ext_write_enable);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        do_reset();
        for (int unsigned i = 0; i < N; i++) set_req(i, 12'h300 + 12'(i), EXT_WRITE, 32'(i + 100));
        tick();
        for (int unsigned i = 0; i < N; i++) begin
            exp_g = N'(1) << i;
            @(negedge clk);
            checks++;
            if (bus.gnt !== exp_g || bus.ext_addr !== 12'h300 + 12'(i) || bus.ext_data !== 32'(i + 100)) begin
                errors++;
                $display("FAIL rr_order[%0d]: gnt=%b addr=%h data=%0d required %b/%h/%0d",
                         i, bus.gnt, bus.ext_addr, bus.ext_data, exp_g, 12'h300 + 12'(i), i + 100);
            end
            tick();
            bus.req[i] = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain: busy=%b required 0", bus.busy);
        end
        tick();
    endtask

    task automatic test_conflict();
        do_reset();
        set_req(0, 12'h305, EXT_CLEAR, 32'hF0);
        bus.core_csr_enable = 1'b1;
        bus.core_csr_addr = 12'h305;
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.gnt !== 4'b0000 || bus.ext_write_enable !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL conflict_hold[%0d]: gnt=%b we=%b busy=%b required 0000/0/1",
                         c, bus.gnt, bus.ext_write_enable, bus.busy);
            end
            tick();
        end
        bus.core_csr_enable = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0001 || bus.ext_write_enable !== 1'b1 || bus.ext_addr !== 12'h305) begin
            errors++;
            $display("FAIL conflict_release: gnt=%b we=%b addr=%h required 0001/1/305",
                     bus.gnt, bus.ext_write_enable, bus.ext_addr);
        end
        tick();
        bus.req = '0;
        do_reset();
        set_req(0, 12'h305, EXT_WRITE, 32'h1);
        bus.core_csr_enable = 1'b1;
        bus.core_csr_addr = 12'h306;
        tick();
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0001 || bus.ext_write_enable !== 1'b1) begin
            errors++;
            $display("FAIL conflict_other_addr: gnt=%b we=%b required 0001/1",
                     bus.gnt, bus.ext_write_enable);
        end
        tick();
        bus.req = '0;
        bus.core_csr_enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        int unsigned cnt = 1;
        logic [N-1:0] exp_g;
        do_reset();
        set_req(2, 12'h340, EXT_WRITE, 32'(cnt));
        tick();
        for (int c = 0; c < 6; c++) begin
            exp_g = (c % 2 == 0) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            checks++;
            if (bus.gnt !== exp_g) begin
                errors++;
                $display("FAIL b2b_gnt[%0d]: gnt=%b required %b", c, bus.gnt, exp_g);
            end
            if (exp_g != 0) begin
                checks++;
                if (bus.ext_data !== 32'(cnt)) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: data=%0d required %0d", c, bus.ext_data, cnt);
                end
            end
            tick();
            if (exp_g != 0) begin
                checks++;
                if (dut.rr_ptr_q !== 2'd3) begin
                    errors++;
                    $display("FAIL b2b_ptr[%0d]: rr_ptr=%0d required 3", c, dut.rr_ptr_q);
                end
                cnt++;
                set_req(2, 12'h340, EXT_WRITE, 32'(cnt));
            end
        end
        bus.req = '0;
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        set_req(2, 12'h310, EXT_SET, 32'h55);
        tick();
        bus.core_csr_enable = 1'b1;
        bus.core_csr_addr = 12'h310;
        tick();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0000 || bus.ext_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL hold_reset_cycle: gnt=%b we=%b required 0000/0", bus.gnt, bus.ext_write_enable);
        end
        tick();
        reset = 1'b0;
        bus.core_csr_enable = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0000 || bus.ext_write_enable !== 1'b0 || bus.busy !== 1'b0 ||
            bus.ext_addr !== 12'h000 || bus.ext_op !== EXT_WRITE || bus.ext_data !== 32'h0) begin
            errors++;
            $display("FAIL hold_reset_clear: gnt=%b we=%b busy=%b addr=%h op=%0d data=%h required all 0",
                     bus.gnt, bus.ext_write_enable, bus.busy, bus.ext_addr, bus.ext_op, bus.ext_data);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0100 || bus.ext_addr !== 12'h310) begin
            errors++;
            $display("FAIL hold_reset_rearb: gnt=%b addr=%h required 0100/310", bus.gnt, bus.ext_addr);
        end
        tick();
        bus.req = '0;
    endtask

    task automatic test_rr_after_last();
        do_reset();
        set_req(1, 12'h301, EXT_WRITE, 32'h11);
        tick();
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0010) begin
            errors++;
            $display("FAIL rr_prime: gnt=%b required 0010", bus.gnt);
        end
        tick();
        set_req(1, 12'h301, EXT_WRITE, 32'h12);
        set_req(2, 12'h302, EXT_WRITE, 32'h22);
        tick();
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0100 || bus.ext_data !== 32'h22) begin
            errors++;
            $display("FAIL rr_first: gnt=%b data=%h required 0100/22", bus.gnt, bus.ext_data);
        end
        tick();
        bus.req[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0010 || bus.ext_data !== 32'h12) begin
            errors++;
            $display("FAIL rr_second: gnt=%b data=%h required 0010/12", bus.gnt, bus.ext_data);
        end
        tick();
        bus.req = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] exp_g;
        logic [N-1:0] seen_g;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            exp_g = m_we() ? (N'(1) << m_idx) : '0;
            checks++;
            if (bus.gnt !== exp_g || bus.ext_write_enable !== m_we() || bus.busy !== m_valid) begin
                errors++;
                $display("FAIL rand_ctrl@%0d: gnt=%b we=%b busy=%b required %b/%b/%b",
                         cyc, bus.gnt, bus.ext_write_enable, bus.busy, exp_g, m_we(), m_valid);
            end
            if (m_we()) begin
                checks++;
                if (bus.ext_addr !== m_addr || bus.ext_op !== m_op || bus.ext_data !== m_data) begin
                    errors++;
                    $display("FAIL rand_data@%0d: addr=%h op=%0d data=%h required %h/%0d/%h",
                             cyc, bus.ext_addr, bus.ext_op, bus.ext_data, m_addr, m_op, m_data);
                end
            end
            seen_g = exp_g;
            tick();
            reset = ($urandom_range(0, 59) == 0);
            bus.core_csr_enable = ($urandom_range(0, 9) < 4);
            bus.core_csr_addr = 12'h300 + 12'($urandom_range(0, 3));
            for (int unsigned i = 0; i < N; i++) begin
                if (bus.req[i] && seen_g[i]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_req(i, 12'h300 + 12'($urandom_range(0, 3)),
                                ext_csr_op_t'(2'($urandom_range(0, 2))), $urandom);
                    else
                        bus.req[i] = 1'b0;
                end else if (!bus.req[i] && $urandom_range(0, 9) < 3) begin
                    set_req(i, 12'h300 + 12'($urandom_range(0, 3)),
                            ext_csr_op_t'(2'($urandom_range(0, 2))), $urandom);
                end
            end
        end
        reset = 1'b0;
        bus.req = '0;
        bus.core_csr_enable = 1'b0;
    endtask

    initial begin
        bus.req = '0;
        bus.req_addr = '0;
        bus.req_op = '{default: EXT_WRITE};
        bus.req_data = '0;
        bus.core_csr_enable = 1'b0;
        bus.core_csr_addr = '0;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_conflict();
        test_back_to_back();
        test_reset_in_hold();
        test_rr_after_last();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_ext_arbiter.md
# csr_ext_arbiter

Shares the external write port of the CSR bank (`ext_data` / `ext_write_enable` path) between several hardware requesters, such as the interrupt controller, timer and debug unit. It picks one requester per cycle by round-robin and registers the chosen address, op and data into a single issue slot. The write is issued to the bank unless a core CSR instruction is accessing the same address in that cycle, in which case it is held and retried. The block sits between the peripherals and the `csr` bank, alongside the decoder-driven core CSR path.

## Interface
Parameters:
- `NumReq`, 4: number of hardware requesters (≥2).
- `CsrWidth`, 32: data width of the CSR bank.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in `NumReq`: per-requester write request.
- `req_addr` in `NumReq` × `csr_addr_t`: target CSR address.
- `req_op` in `NumReq` × `ext_csr_op_t`: `EXT_WRITE` / `EXT_SET` / `EXT_CLEAR`.
- `req_data` in `NumReq` × `CsrWidth`: write data or bit mask.
- `core_csr_enable` in 1: a core CSR instruction is active this cycle.
- `core_csr_addr` in `csr_addr_t`: address of that instruction.
- `gnt` out `NumReq`: one-hot pulse; the requester's write is committed this cycle.
- `ext_addr` out `csr_addr_t`: address of the write to the bank.
- `ext_op` out `ext_csr_op_t`: op of the write to the bank.
- `ext_data` out `CsrWidth`: data of the write to the bank.
- `ext_write_enable` out 1: strobe to the bank.
- `busy` out 1: the issue slot holds a pending write.

## Operation
Issue slot contents: `slot_valid`, `slot_idx`, `slot_addr`, `slot_op`, `slot_data`.

State machine:
- IDLE: `slot_valid` = 0.
- ISSUE: slot loaded; the write is presented to the bank.
- HOLD: ISSUE blocked by a core address conflict; slot contents frozen.

Arbitration, evaluated every cycle:
- Eligible set = `req` & ~mask. Mask is the one-hot of `slot_idx` while `slot_valid`, so the requester being issued is not re-picked.
- Winner = first eligible index at or after `rr_ptr`, wrapping from `NumReq`-1 to 0.

Conflict and issue:
- `conflict` = `slot_valid` && `core_csr_enable` && (`core_csr_addr` == `slot_addr`).
- `ext_write_enable` = `slot_valid` && !`conflict`.
- `gnt[slot_idx]` = `ext_write_enable`; all other `gnt` bits are 0.

Slot update at each edge:
- If the slot is empty or was issued this cycle, load the winner if one exists; otherwise clear `slot_valid`.
- If the slot is blocked (`conflict`), keep it unchanged (HOLD) and pick no new winner.

Round-robin pointer:
- On a successful issue, `rr_ptr` ← `slot_idx`+1 mod `NumReq`.
- A blocked issue does not move `rr_ptr`.

Requester handshake:
- Hold `req`, `req_addr`, `req_op` and `req_data` stable from assertion until the cycle `gnt` is high.
- Deassert `req`, or present the next request, at the following edge.
- The arbiter samples payload only at the load edge. Changing payload after load has no effect on the current write.

Op semantics belong to the bank: write replaces the value, set ORs the mask in, clear ANDs its complement.

## Timing
Reset values:
- `gnt` = 0, `ext_write_enable` = 0, `busy` = 0.
- `ext_addr`, `ext_op`, `ext_data` = 0.
- `rr_ptr` = 0, state = IDLE.

Latency and throughput:
- `req` high in cycle n with the slot free → `gnt` and `ext_write_enable` in cycle n+1 (no conflict).
- Throughput is one write per cycle: a different requester loads at the same edge the current one issues.
- A single requester with back-to-back requests gets a write every 2 cycles, because of the self-mask.

Boundary conditions:
- Conflict persisting k cycles → issue delayed by k cycles. Starvation is bounded by core behaviour only.
- Simultaneous requests to the same address from different requesters are serialized in round-robin order; no merging.
- `req` dropped while loaded but not yet granted: the loaded write still issues (committed at load).
- Reset in HOLD or ISSUE: the slot is discarded with no `gnt`. Requesters still asserting `req` are re-arbitrated from `rr_ptr` = 0 starting in the first cycle after reset.

## Structure
- `decoder_pkg` additions:
  - `ext_csr_op_t` (2-bit enum: `EXT_WRITE`, `EXT_SET`, `EXT_CLEAR`).
  - Reuse `csr_addr_t`.
- Sub-module `rr_picker`: combinational; takes `NumReq` request bits and a pointer, returns a valid flag and the winner index.
- `csr_ext_arbiter` holds the slot registers, the pointer, the conflict logic and the FSM.

## Test plan
- Reset, then `req` = 0001 (addr 0x300, `EXT_SET`, data 0x8) → `gnt` = 0001 and `ext_write_enable` one cycle later with addr 0x300, op `EXT_SET`, data 0x8; then `busy` = 0.
- `req` = 1111 held continuously, releasing each after its `gnt` → grants in order 0,1,2,3 on consecutive cycles starting one cycle after assertion.
- Slot holds addr 0x305 with `core_csr_enable` = 1 and `core_csr_addr` = 0x305 for 3 cycles → `ext_write_enable` = 0 and `gnt` = 0 for 3 cycles, issue on the 4th. With `core_csr_addr` = 0x306 instead → issue with no delay.
- Requester 2 alone with back-to-back requests → `gnt[2]` every other cycle; `rr_ptr` = 3 after each grant.
- Assert `reset` in the cycle a slot is in HOLD → no `gnt`, all outputs 0 the next cycle; with `req` still 0100, `gnt[2]` two cycles after reset is released.
- `req` = 0110 after requester 1 was last granted → requester 2 granted before requester 1.
